// File: rtl/bdi_line_serializer.sv
// Buffers compressed BDI lines in a DEPTH-entry FIFO and emits each as 64-bit beats; beat 0 appears the cycle after the push into an idle, empty block.
// Backpressure: beats hold stable while out_ready is low; in_ready drops only when the FIFO is full, regardless of a same-cycle pop.
module bdi_line_serializer #(
    parameter int DEPTH  = 2,
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LINE_W-1:0] in_line,
    input  logic [3:0]        in_enc,
    input  logic [5:0]        in_size,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BEAT_W-1:0] out_data,
    output logic [3:0]        out_enc,
    output logic              out_first,
    output logic              out_last,
    output logic [3:0]        out_bytes,
    output logic              busy
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int KW = $clog2(LINE_W / BEAT_W);
    localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    logic [LINE_W-1:0] r_line [DEPTH];
    logic [3:0]        r_enc  [DEPTH];
    logic [5:0]        r_size [DEPTH];
    logic [PW-1:0]     r_wptr, r_rptr;
    logic [CW-1:0]     r_count;
    logic [KW-1:0]     r_k;
    state_t            r_state, w_state_nxt;

    logic              w_push, w_pop;
    logic [5:0]        w_size_clamped, w_head_size, w_rem;
    logic [KW-1:0]     w_last_k;
    logic [3:0]        w_bytes;
    logic [BEAT_W-1:0] w_beat;

    assign in_ready       = !rst && (r_count < L_DEPTH);
    assign w_push         = in_valid && in_ready;
    assign w_size_clamped = (in_size > 6'd32) ? 6'd32 : in_size;

    // The serializer reads the FIFO head in place; the entry is released on its last beat.
    assign w_head_size = r_size[r_rptr];
    assign w_last_k    = (w_head_size == 6'd0) ? '0 : KW'((w_head_size - 6'd1) >> 3);
    assign w_rem       = w_head_size - {1'b0, r_k, 3'b000};
    assign w_bytes     = (w_rem >= 6'd8) ? 4'd8 : w_rem[3:0];
    assign w_beat      = r_line[r_rptr][r_k * BEAT_W +: BEAT_W];
    assign w_pop       = (r_state == S_SEND) && out_ready && (r_k == w_last_k);
    assign busy        = (r_count != '0) || (r_state == S_SEND);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_line[r_wptr] <= in_line;
            r_enc[r_wptr]  <= in_enc;
            r_size[r_wptr] <= w_size_clamped;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_k     <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (r_state != S_SEND || w_pop)
                r_k <= '0;
            else if (out_ready)
                r_k <= r_k + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_push || r_count != '0) w_state_nxt = S_SEND;
            S_SEND:  if (w_pop && r_count == CW'(1) && !w_push) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_enc   = '0;
        out_first = 1'b0;
        out_last  = 1'b0;
        out_bytes = '0;
        if (r_state == S_SEND) begin
            out_valid = 1'b1;
            out_enc   = r_enc[r_rptr];
            out_first = (r_k == '0);
            out_last  = (r_k == w_last_k);
            out_bytes = w_bytes;
            for (int i = 0; i < BEAT_W / 8; i++) begin
                if (4'(i) < w_bytes) out_data[8*i +: 8] = w_beat[8*i +: 8];
            end
        end
    end
endmodule
